matrix_mixer: RTL and testbench

MATRIX_MIXER -- requirements
Module: matrix_mixer

---
 rtl/matrix_mixer.sv | 133 +++++++++++++
 tb/tb_matrix_mixer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/matrix_mixer.sv
// matrix_mixer: four-channel gain-weighted audio mixer with a saturated, registered output
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   in1..in4       BITSIZE-bit signed samples
//   gain1..gain4   8-bit unsigned Q1.7 gains (128 = 1.0)
//   sample_strobe  one-cycle pulse that starts a mix while idle
//   out            registered, saturated signed mix result
//   out_valid      one-cycle pulse coincident with a new out value
//   busy           high while a mix is in progress
//   overrun        sticky flag: a strobe arrived while busy (cleared only by reset)
module matrix_mixer #(
    parameter int BITSIZE = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BITSIZE-1:0] in1,
    input  logic [BITSIZE-1:0] in2,
    input  logic [BITSIZE-1:0] in3,
    input  logic [BITSIZE-1:0] in4,
    input  logic [7:0]         gain1,
    input  logic [7:0]         gain2,
    input  logic [7:0]         gain3,
    input  logic [7:0]         gain4,
    input  logic               sample_strobe,
    output logic [BITSIZE-1:0] out,
    output logic               out_valid,
    output logic               busy,
    output logic               overrun
);
    localparam int PW = BITSIZE + 9;
    localparam int AW = BITSIZE + 11;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t             state_q, state_d;
    logic [BITSIZE-1:0] in_q [4];
    logic [7:0]         gain_q [4];
    logic [AW-1:0]      acc_q, acc_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [BITSIZE-1:0] out_q, out_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;
    logic               capture;
    logic [BITSIZE-1:0] sel_in;
    logic [7:0]         sel_gain;
    logic [PW-1:0]      prod;
    logic [4:0]         hi;
    logic               ovf;
    logic [BITSIZE-1:0] sat;

    // Two's-complement bit patterns: sign-extend the sample, zero-extend the gain;
    // the low PW bits of the unsigned product equal the signed product.
    assign sel_in   = in_q[cnt_q];
    assign sel_gain = gain_q[cnt_q];
    assign prod     = {{9{sel_in[BITSIZE-1]}}, sel_in} * {{(PW-8){1'b0}}, sel_gain};

    // Dropping the low 7 bits is the floor shift; the result fits BITSIZE
    // only when acc bits [AW-1:BITSIZE+6] are all equal.
    assign hi  = acc_q[AW-1:BITSIZE+6];
    assign ovf = !(&hi || ~|hi);
    assign sat = !ovf ? acc_q[BITSIZE+6:7] :
                 acc_q[AW-1] ? {1'b1, {(BITSIZE-1){1'b0}}} : {1'b0, {(BITSIZE-1){1'b1}}};

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        valid_d   = 1'b0;
        capture   = 1'b0;
        overrun_d = overrun_q | (sample_strobe && state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (sample_strobe) begin
                    capture = 1'b1;
                    acc_d   = '0;
                    cnt_d   = 2'd0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d   = acc_q + {{(AW-PW){prod[PW-1]}}, prod};
                cnt_d   = cnt_q + 2'd1;
                state_d = cnt_q == 2'd3 ? OUT : MAC;
            end
            OUT: begin
                out_d   = sat;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= 2'd0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                in_q[i]   <= '0;
                gain_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            if (capture) begin
                in_q[0]   <= in1;
                in_q[1]   <= in2;
                in_q[2]   <= in3;
                in_q[3]   <= in4;
                gain_q[0] <= gain1;
                gain_q[1] <= gain2;
                gain_q[2] <= gain3;
                gain_q[3] <= gain4;
            end
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign busy      = state_q != IDLE;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_matrix_mixer.sv
// tb_matrix_mixer: table-driven, randomized and sequence checks of matrix_mixer
module tb_matrix_mixer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in1 = '0, in2 = '0, in3 = '0, in4 = '0;
    logic [7:0]  gain1 = '0, gain2 = '0, gain3 = '0, gain4 = '0;
    logic        sample_strobe = 1'b0;
    logic [15:0] out;
    logic        out_valid, busy, overrun;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int i[4];
        int g[4];
        int exp;
    } vec_t;

    matrix_mixer #(.BITSIZE(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .gain1(gain1), .gain2(gain2), .gain3(gain3), .gain4(gain4),
        .sample_strobe(sample_strobe),
        .out(out), .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: exact integer mix, floor divide by 128, clamp to 16-bit range.
    function automatic int model(input vec_t v);
        int s = 0;
        for (int c = 0; c < 4; c++) s += v.i[c] * v.g[c];
        s = s >>> 7;
        return s > 32767 ? 32767 : s < -32768 ? -32768 : s;
    endfunction

    task automatic drive(input vec_t v);
        in1 = 16'(v.i[0]); in2 = 16'(v.i[1]); in3 = 16'(v.i[2]); in4 = 16'(v.i[3]);
        gain1 = 8'(v.g[0]); gain2 = 8'(v.g[1]); gain3 = 8'(v.g[2]); gain4 = 8'(v.g[3]);
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int c = 0; c < 4; c++) begin
            v.i[c] = int'($urandom_range(65535)) - 32768;
            v.g[c] = int'($urandom_range(255));
        end
        v.exp = 0;
        return v;
    endfunction

    // Called on a falling edge. Strobe is sampled by the next rising edge (edge 1);
    // the result must appear after edge 6 and only once within 10 edges.
    task automatic mix_once(input vec_t v, input bit scramble,
                            output int res, output int lat, output int nv);
        vec_t r;
        res = 0; lat = 0; nv = 0;
        drive(v);
        sample_strobe = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            sample_strobe = 1'b0;
            if (out_valid) begin
                nv++;
                if (lat == 0) begin
                    lat = k;
                    res = int'($signed(out));
                end
            end
            if (scramble) begin
                r = rand_vec();
                drive(r);
            end
        end
    endtask

    vec_t tbl[6];
    vec_t va, vb;
    int res, lat, nv, nva, resa, resb, lata, latb;

    initial begin
        tbl[0] = '{i: '{1000, 0, 0, 0}, g: '{128, 0, 0, 0}, exp: 1000};
        tbl[1] = '{i: '{-1001, 0, 0, 0}, g: '{64, 0, 0, 0}, exp: -501};
        tbl[2] = '{i: '{100, 100, 100, 100}, g: '{128, 128, 128, 128}, exp: 400};
        tbl[3] = '{i: '{30000, 30000, 30000, 30000}, g: '{255, 255, 255, 255}, exp: 32767};
        tbl[4] = '{i: '{-32768, -32768, -32768, -32768}, g: '{255, 255, 255, 255}, exp: -32768};
        tbl[5] = '{i: '{12345, -32768, 32767, -7}, g: '{0, 0, 0, 0}, exp: 0};

        repeat (2) @(negedge clk);
        check("reset_out", int'(out), 0);
        check("reset_valid", int'(out_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_overrun", int'(overrun), 0);
        rst_n = 1'b1;

        // First strobe right after release must be honoured.
        for (int t = 0; t < 6; t++) begin
            mix_once(tbl[t], 1'b0, res, lat, nv);
            check($sformatf("vec%0d_out", t), res, tbl[t].exp);
            check($sformatf("vec%0d_latency", t), lat, 6);
            check($sformatf("vec%0d_pulses", t), nv, 1);
        end

        for (int t = 0; t < 24; t++) begin
            va = rand_vec();
            if (t % 4 == 0) for (int c = 0; c < 4; c++) va.g[c] = 255;
            mix_once(va, t[0], res, lat, nv);
            check($sformatf("rand%0d_out", t), res, model(va));
            check($sformatf("rand%0d_latency", t), lat, 6);
        end
        check("no_overrun_yet", int'(overrun), 0);

        // Overrun: second strobe two edges later is ignored; a strobe in the
        // first idle cycle (during out_valid) starts a normal second mix.
        va = rand_vec();
        vb = rand_vec();
        drive(va);
        sample_strobe = 1'b1;
        nva = 0; lata = 0; latb = 0; resa = 0; resb = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (out_valid) begin
                nva++;
                if (lata == 0) begin lata = k; resa = int'($signed(out)); end
                else if (latb == 0) begin latb = k; resb = int'($signed(out)); end
            end
            if (k == 4) check("overrun_set", int'(overrun), 1);
            if (k == 6) check("busy_low_at_return", int'(busy), 0);
            sample_strobe = (k == 2) || (k == 6);
            if (k == 2) drive(vb);
            if (k == 6) drive(vb);
            if (k == 3) drive(va);
        end
        check("ovr_first_latency", lata, 6);
        check("ovr_first_out", resa, model(va));
        check("ovr_second_latency", latb, 12);
        check("ovr_second_out", resb, model(vb));
        check("ovr_pulses", nva, 2);
        check("overrun_sticky", int'(overrun), 1);
        check("out_holds", int'($signed(out)), model(vb));

        // Reset two cycles into a mix aborts it with no result afterwards.
        va = rand_vec();
        va.g[0] = 200;
        va.i[0] = 20000;
        drive(va);
        sample_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_out", int'(out), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_valid", int'(out_valid), 0);
        check("midreset_overrun", int'(overrun), 0);
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            nv += int'(out_valid);
        end
        check("midreset_no_valid", nv, 0);
        check("midreset_idle", int'(busy), 0);
        mix_once(va, 1'b0, res, lat, nv);
        check("post_reset_out", res, model(va));
        check("post_reset_latency", lat, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
